ce_divider: RTL and testbench

Parametrised clock-enable generator. From the single system clock it produces per-channel positive-phase (`ce_p`) and half-period (`ce_n`) enable strobes. Each channel has two runtime-selectable divisor sets, for example a normal and a turbo CPU speed. A set change is committed only at a period boundary, and only when the channel's `hold` input is low. This lets the CPU, PSG and video enables of the system top level come from one block, with the speed change deferred while a bus cycle is in progress.

---
 rtl/ce_divider.sv | 86 ++++++++
 tb/tb_ce_divider.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ce_divider.sv
// Multi-channel clock-enable generator: per-channel period (ce_p) and mid-period (ce_n)
// strobes, with a runtime-selectable divisor set that is committed only at a period wrap.
module ce_divider #(
  parameter int CHANNELS = 3,
  parameter int WIDTH    = 6
) (
  input  logic                      clk_sys,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] div_a,
  input  logic [CHANNELS*WIDTH-1:0] div_b,
  input  logic [CHANNELS-1:0]       sel_b,
  input  logic [CHANNELS-1:0]       hold,
  output logic [CHANNELS-1:0]       ce_p,
  output logic [CHANNELS-1:0]       ce_n,
  output logic [CHANNELS-1:0]       active_b
);

  logic [WIDTH-1:0]    cnt_q [CHANNELS];
  logic [WIDTH-1:0]    cnt_d [CHANNELS];
  logic [WIDTH-1:0]    p_q   [CHANNELS];
  logic [WIDTH-1:0]    p_d   [CHANNELS];
  logic [CHANNELS-1:0] act_q, act_d;
  logic [CHANNELS-1:0] ce_p_q, ce_p_d;
  logic [CHANNELS-1:0] ce_n_q, ce_n_d;

  // Count value at which the half-period strobe is due; P+1 is formed one bit wider
  // so that an all-ones period does not wrap to zero.
  function automatic logic [WIDTH:0] mid_count(input logic [WIDTH-1:0] p);
    logic [WIDTH:0] half;
    half = ({1'b0, p} + (WIDTH+1)'(1)) >> 1;
    return half - (WIDTH+1)'(1);
  endfunction

  always_comb begin
    // NOTE: every combinational output is given a default first, so no latch is inferred.
    act_d  = act_q;
    ce_p_d = '0;
    ce_n_d = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      cnt_d[i] = cnt_q[i];
      p_d[i]   = p_q[i];
      if (en[i]) begin
        ce_n_d[i] = (p_q[i] != '0) && ({1'b0, cnt_q[i]} == mid_count(p_q[i]));
        // The >= is defensive: cnt never exceeds P in normal operation.
        if (cnt_q[i] >= p_q[i]) begin
          cnt_d[i]  = '0;
          ce_p_d[i] = 1'b1;
          if (!hold[i]) begin
            act_d[i] = sel_b[i];
            p_d[i]   = sel_b[i] ? div_b[i*WIDTH +: WIDTH] : div_a[i*WIDTH +: WIDTH];
          end
        end else begin
          cnt_d[i] = cnt_q[i] + WIDTH'(1);
        end
      end
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the per-channel arrays are small registers, not memories, so they are reset.
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= '0;
        p_q[i]   <= '0;
      end
      act_q  <= '0;
      ce_p_q <= '0;
      ce_n_q <= '0;
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        cnt_q[i] <= cnt_d[i];
        p_q[i]   <= p_d[i];
      end
      act_q  <= act_d;
      ce_p_q <= ce_p_d;
      ce_n_q <= ce_n_d;
    end
  end

  assign ce_p     = ce_p_q;
  assign ce_n     = ce_n_q;
  assign active_b = act_q;

endmodule

// File: tb/tb_ce_divider.sv
// Randomised and directed bench for ce_divider: a period-level reference model pushes the
// expected strobes per clock into a queue, and a monitor pops and compares on each falling edge.
module tb_ce_divider;

  localparam int CH = 3;
  localparam int W  = 6;

  logic            clk_sys;
  logic            reset_n;
  logic [CH-1:0]   en;
  logic [CH*W-1:0] div_a;
  logic [CH*W-1:0] div_b;
  logic [CH-1:0]   sel_b;
  logic [CH-1:0]   hold;
  logic [CH-1:0]   ce_p;
  logic [CH-1:0]   ce_n;
  logic [CH-1:0]   active_b;

  ce_divider #(.CHANNELS(CH), .WIDTH(W)) dut (
    .clk_sys  (clk_sys),
    .reset_n  (reset_n),
    .en       (en),
    .div_a    (div_a),
    .div_b    (div_b),
    .sel_b    (sel_b),
    .hold     (hold),
    .ce_p     (ce_p),
    .ce_n     (ce_n),
    .active_b (active_b)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [CH-1:0] ce_p;
    logic [CH-1:0] ce_n;
    logic [CH-1:0] act;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: position within the current period and the period length in clocks.
  int m_pos [CH];
  int m_len [CH];
  bit m_act [CH];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, req);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < CH; i++) begin
      m_pos[i] = 0;
      m_len[i] = 1;
      m_act[i] = 1'b0;
    end
  endtask

  function automatic int chan_div(input logic [CH*W-1:0] v, input int i);
    logic [W-1:0] f;
    f = v[i*W +: W];
    return int'(f);
  endfunction

  // Predict the outputs after the coming rising edge, queue them, then move to the next cycle.
  task automatic cycle();
    exp_t e;
    e.ce_p = '0;
    e.ce_n = '0;
    e.act  = '0;
    if (!reset_n) begin
      model_reset();
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (en[i]) begin
          e.ce_n[i] = (m_len[i] >= 2) && (m_pos[i] == m_len[i] / 2 - 1);
          if (m_pos[i] >= m_len[i] - 1) begin
            e.ce_p[i] = 1'b1;
            m_pos[i]  = 0;
            if (!hold[i]) begin
              m_act[i] = sel_b[i];
              m_len[i] = (sel_b[i] ? chan_div(div_b, i) : chan_div(div_a, i)) + 1;
            end
          end else begin
            m_pos[i] = m_pos[i] + 1;
          end
        end
        e.act[i] = m_act[i];
      end
    end
    exp_q.push_back(e);
    @(negedge clk_sys);
    #1;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  // Assert reset between edges and confirm the outputs clear without a clock.
  task automatic async_reset(input int low_cycles);
    reset_n = 1'b0;
    #1;
    check("async_reset_ce_p", 32'(ce_p), 32'(0));
    check("async_reset_ce_n", 32'(ce_n), 32'(0));
    check("async_reset_active_b", 32'(active_b), 32'(0));
    model_reset();
    run(low_cycles);
    reset_n = 1'b1;
  endtask

  always @(negedge clk_sys) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("ce_p", 32'(ce_p), 32'(e.ce_p));
      check("ce_n", 32'(ce_n), 32'(e.ce_n));
      check("active_b", 32'(active_b), 32'(e.act));
    end
  end

  initial begin
    reset_n = 1'b0;
    en      = '1;
    sel_b   = '0;
    hold    = '0;
    div_a   = {6'd55, 6'd7, 6'd23};
    div_b   = {6'd3, 6'd2, 6'd11};
    model_reset();
    #1;
    check("reset_ce_p", 32'(ce_p), 32'(0));
    check("reset_ce_n", 32'(ce_n), 32'(0));
    check("reset_active_b", 32'(active_b), 32'(0));
    run(3);

    // Cases 1 and 2: period 24 on ch0, switch to set B (period 12) requested at clock 30.
    reset_n = 1'b1;
    run(29);
    sel_b[0] = 1'b1;
    run(70);

    // Case 3: same request, but hold is high around the wrap at clock 49.
    async_reset(2);
    sel_b = '0;
    reset_n = 1'b1;
    run(29);
    sel_b[0] = 1'b1;
    run(15);
    hold[0] = 1'b1;
    run(6);
    hold[0] = 1'b0;
    run(60);

    // Case 4: divisor 0 then divisor 1 on channel 0.
    sel_b = '0;
    div_a[0 +: W] = 6'd0;
    run(40);
    div_a[0 +: W] = 6'd1;
    run(30);

    // Case 5: en low for 5 clocks mid-period.
    div_a[0 +: W] = 6'd23;
    run(40);
    en[0] = 1'b0;
    run(5);
    en[0] = 1'b1;
    run(60);

    // Case 6: reset mid-period on all three channels with divisors 23/7/55.
    div_a = {6'd55, 6'd7, 6'd23};
    run(17);
    async_reset(1);
    run(120);

    // Randomised phase: enables, holds, set selection, divisor changes and reset pulses.
    for (int k = 0; k < 3000; k++) begin
      for (int i = 0; i < CH; i++) begin
        en[i]   = ($urandom_range(0, 99) < 90);
        hold[i] = ($urandom_range(0, 99) < 30);
        if ($urandom_range(0, 99) < 10) sel_b[i] = ~sel_b[i];
        if ($urandom_range(0, 99) < 5)
          div_a[i*W +: W] = ($urandom_range(0, 9) == 0) ? 6'd63 : W'($urandom_range(0, 7));
        if ($urandom_range(0, 99) < 5)
          div_b[i*W +: W] = ($urandom_range(0, 9) == 0) ? 6'd63 : W'($urandom_range(0, 7));
      end
      if ($urandom_range(0, 999) < 3) async_reset(int'($urandom_range(1, 3)));
      else cycle();
    end

    check("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
